cep_delta_calc: RTL and testbench

CEP_DELTA_CALC -- requirements
Module: cep_delta_calc

---
 rtl/cep_delta_calc_pkg.sv | 21 ++
 rtl/cep_delta_calc_delta_weighted_sum.sv | 108 ++++++++++
 rtl/cep_delta_calc.sv | 114 +++++++++++
 tb/tb_cep_delta_calc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cep_delta_calc_pkg.sv
// cep_delta_calc_pkg
// Shared constants and types for the MFCC delta stage: default coefficient
// width, coefficients per frame, index width, the number of history frames
// that must be filled before deltas are meaningful, and the FSM encoding.
// No ports; imported by cep_delta_calc and delta_weighted_sum.
package cep_delta_calc_pkg;

  localparam int CEP_DATA_WIDTH  = 16;
  localparam int CEP_NUM         = 13;
  localparam int CEP_IDX_WIDTH   = 6;

  // Frames of history (h1..h4) needed before the first delta is valid.
  localparam int CEP_FILL_FRAMES = 4;
  localparam int CEP_FCNT_WIDTH  = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } delta_state_e;

endpackage

// File: rtl/cep_delta_calc_delta_weighted_sum.sv
// delta_weighted_sum
// Two-stage arithmetic for the cepstral delta:
//   stage 1: a = c_t - h4, b = h1 - h3   (operands sign-extended by 3 bits)
//   stage 2: D = 2*a + b
// The extra 3 bits make overflow impossible, so no saturation is needed.
// idx and last travel alongside the data; all outputs are zero when not valid.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/idx/last     strobe, coefficient index, last-coefficient flag
//   c_t, h1, h3, h4       current coefficient and pre-shift history values
//   out_valid/idx/data/last  registered result, 2 cycles after in_valid
module delta_weighted_sum
  import cep_delta_calc_pkg::*;
#(
  parameter int DATA_WIDTH = CEP_DATA_WIDTH,
  parameter int IDX_WIDTH  = CEP_IDX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [IDX_WIDTH-1:0]         in_idx,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] c_t,
  input  logic signed [DATA_WIDTH-1:0] h1,
  input  logic signed [DATA_WIDTH-1:0] h3,
  input  logic signed [DATA_WIDTH-1:0] h4,
  output logic                         out_valid,
  output logic [IDX_WIDTH-1:0]         out_idx,
  output logic signed [DATA_WIDTH+2:0] out_data,
  output logic                         out_last
);

  localparam int OW = DATA_WIDTH + 3;

  logic                 s1_valid_q, s1_valid_d;
  logic [IDX_WIDTH-1:0] s1_idx_q,   s1_idx_d;
  logic                 s1_last_q,  s1_last_d;
  logic signed [OW-1:0] s1_a_q,     s1_a_d;
  logic signed [OW-1:0] s1_b_q,     s1_b_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [IDX_WIDTH-1:0] s2_idx_q,   s2_idx_d;
  logic                 s2_last_q,  s2_last_d;
  logic signed [OW-1:0] s2_data_q,  s2_data_d;

  logic signed [OW-1:0] c_x, h1_x, h3_x, h4_x;

  assign c_x  = {{3{c_t[DATA_WIDTH-1]}}, c_t};
  assign h1_x = {{3{h1[DATA_WIDTH-1]}},  h1};
  assign h3_x = {{3{h3[DATA_WIDTH-1]}},  h3};
  assign h4_x = {{3{h4[DATA_WIDTH-1]}},  h4};

  // Stage 1 differences and stage 2 weighted sum; sidebands are zeroed
  // whenever their stage is empty so outputs read as 0 when not valid.
  always_comb begin
    s1_valid_d = in_valid;
    s1_idx_d   = '0;
    s1_last_d  = 1'b0;
    s1_a_d     = '0;
    s1_b_d     = '0;
    if (in_valid) begin
      s1_idx_d  = in_idx;
      s1_last_d = in_last;
      s1_a_d    = c_x - h4_x;
      s1_b_d    = h1_x - h3_x;
    end

    s2_valid_d = s1_valid_q;
    s2_idx_d   = '0;
    s2_last_d  = 1'b0;
    s2_data_d  = '0;
    if (s1_valid_q) begin
      s2_idx_d  = s1_idx_q;
      s2_last_d = s1_last_q;
      s2_data_d = s1_a_q + s1_a_q + s1_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_idx   = s2_idx_q;
  assign out_last  = s2_last_q;
  assign out_data  = s2_data_q;

endmodule

// File: rtl/cep_delta_calc.sv
// cep_delta_calc
// Computes the unscaled cepstral delta D = 2*(c_t - h4) + (h1 - h3) per
// coefficient, using a four-frame per-coefficient history. Deltas are only
// emitted once four complete frames have been seen since reset/clear.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               start of new utterance (resets fill count only)
//   cep_in_valid/idx/data   incoming coefficient stream, no backpressure
//   delta_out_valid/idx/data/last   registered delta, 2 cycles after input
module cep_delta_calc
  import cep_delta_calc_pkg::*;
#(
  parameter int DATA_WIDTH = CEP_DATA_WIDTH,
  parameter int NUM_CEP    = CEP_NUM,
  parameter int IDX_WIDTH  = CEP_IDX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         cep_in_valid,
  input  logic [IDX_WIDTH-1:0]         cep_in_idx,
  input  logic signed [DATA_WIDTH-1:0] cep_in_data,
  output logic                         delta_out_valid,
  output logic [IDX_WIDTH-1:0]         delta_out_idx,
  output logic signed [DATA_WIDTH+2:0] delta_out_data,
  output logic                         delta_out_last
);

  localparam int AW = (NUM_CEP > 1) ? $clog2(NUM_CEP) : 1;

  // History is deliberately not reset: FILL suppresses output until every
  // entry has been rewritten four times.
  logic signed [DATA_WIDTH-1:0] h1_q [NUM_CEP];
  logic signed [DATA_WIDTH-1:0] h2_q [NUM_CEP];
  logic signed [DATA_WIDTH-1:0] h3_q [NUM_CEP];
  logic signed [DATA_WIDTH-1:0] h4_q [NUM_CEP];

  delta_state_e              state_q, state_d;
  logic [CEP_FCNT_WIDTH-1:0] fcnt_q,  fcnt_d;

  logic          [AW-1:0]         addr;
  logic                           idx_ok;
  logic                           idx_last;
  logic                           accept;
  logic                           emit;
  logic signed [DATA_WIDTH-1:0]   h1_rd, h3_rd, h4_rd;

  assign addr     = cep_in_idx[AW-1:0];
  assign idx_ok   = cep_in_idx < IDX_WIDTH'(NUM_CEP);
  assign idx_last = cep_in_idx == IDX_WIDTH'(NUM_CEP - 1);
  // An input that coincides with clear is discarded along with the old state.
  assign accept   = cep_in_valid & ~clear & idx_ok;
  assign emit     = accept & (state_q == ST_RUN);

  assign h1_rd = h1_q[addr];
  assign h3_rd = h3_q[addr];
  assign h4_rd = h4_q[addr];

  // Shift only the addressed column; the reads above see the pre-shift values.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      h4_q[addr] <= h3_q[addr];
      h3_q[addr] <= h2_q[addr];
      h2_q[addr] <= h1_q[addr];
      h1_q[addr] <= cep_in_data;
    end
  end

  // Frame counter saturates at the fill depth; RUN is entered in the same
  // update that completes the fourth frame so the next input already emits.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (clear) begin
      state_d = ST_FILL;
      fcnt_d  = '0;
    end else if (accept && idx_last && fcnt_q != CEP_FCNT_WIDTH'(CEP_FILL_FRAMES)) begin
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_d == CEP_FCNT_WIDTH'(CEP_FILL_FRAMES)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  delta_weighted_sum #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_wsum (
    .clk      (clk),
    .rst      (rst),
    .in_valid (emit),
    .in_idx   (cep_in_idx),
    .in_last  (idx_last),
    .c_t      (cep_in_data),
    .h1       (h1_rd),
    .h3       (h3_rd),
    .h4       (h4_rd),
    .out_valid(delta_out_valid),
    .out_idx  (delta_out_idx),
    .out_data (delta_out_data),
    .out_last (delta_out_last)
  );

endmodule

// File: tb/tb_cep_delta_calc.sv
// tb_cep_delta_calc
// Directed scenarios (fill, ramp, extremes, gaps/bad indices, clear, reset)
// mixed with random data, checked cycle by cycle against a frame-history
// reference model with an expected-output queue.
module tb_cep_delta_calc;

  localparam int DW = 16;
  localparam int NC = 13;
  localparam int IW = 6;

  logic                 clk;
  logic                 rst;
  logic                 clear;
  logic                 cep_in_valid;
  logic [IW-1:0]        cep_in_idx;
  logic signed [DW-1:0] cep_in_data;
  logic                 delta_out_valid;
  logic [IW-1:0]        delta_out_idx;
  logic signed [DW+2:0] delta_out_data;
  logic                 delta_out_last;

  cep_delta_calc #(
    .DATA_WIDTH(DW),
    .NUM_CEP   (NC),
    .IDX_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .cep_in_valid   (cep_in_valid),
    .cep_in_idx     (cep_in_idx),
    .cep_in_data    (cep_in_data),
    .delta_out_valid(delta_out_valid),
    .delta_out_idx  (delta_out_idx),
    .delta_out_data (delta_out_data),
    .delta_out_last (delta_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int idx;
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   hist[NC][4];
  int   frames_seen;
  int   cycle;
  int   checks;
  int   errors;

  // Compare the DUT outputs at this cycle with the head of the expected queue,
  // or with all-zero outputs when nothing is due.
  task automatic checkOutput();
    exp_t                 e;
    bit                   ev;
    int                   eidx;
    bit                   elast;
    logic signed [DW+2:0] edata;
    ev    = 1'b0;
    eidx  = 0;
    elast = 1'b0;
    edata = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      e     = exp_q.pop_front();
      ev    = 1'b1;
      eidx  = e.idx;
      elast = e.last;
      edata = (DW+3)'(e.data);
    end
    checks++;
    assert (delta_out_valid === ev) else begin
      errors++;
      $error("[TB] FAIL valid cyc %0d observed %0b expected %0b", cycle, delta_out_valid, ev);
    end
    checks++;
    assert (delta_out_idx === IW'(eidx)) else begin
      errors++;
      $error("[TB] FAIL idx cyc %0d observed %0d expected %0d", cycle, delta_out_idx, eidx);
    end
    checks++;
    assert (delta_out_data === edata) else begin
      errors++;
      $error("[TB] FAIL data cyc %0d observed %0d expected %0d", cycle, delta_out_data, edata);
    end
    checks++;
    assert (delta_out_last === elast) else begin
      errors++;
      $error("[TB] FAIL last cyc %0d observed %0b expected %0b", cycle, delta_out_last, elast);
    end
  endtask

  // One cycle: check outputs, drive new inputs, and advance the reference
  // model by what those inputs should do at the next rising edge.
  task automatic applyStimulus(input bit v, input int idx, input int data,
                               input bit clr, input bit r);
    exp_t e;
    int   d;
    @(negedge clk);
    cycle++;
    checkOutput();
    cep_in_valid = v;
    cep_in_idx   = IW'(idx);
    cep_in_data  = DW'(data);
    clear        = clr;
    rst          = r;
    if (r) begin
      frames_seen = 0;
      exp_q.delete();
    end else if (clr) begin
      frames_seen = 0;
    end else if (v && idx >= 0 && idx < NC) begin
      if (frames_seen >= 4) begin
        d      = 2 * (data - hist[idx][3]) + (hist[idx][0] - hist[idx][2]);
        e.due  = cycle + 2;
        e.idx  = idx;
        e.data = d;
        e.last = (idx == NC - 1);
        exp_q.push_back(e);
      end
      hist[idx][3] = hist[idx][2];
      hist[idx][2] = hist[idx][1];
      hist[idx][1] = hist[idx][0];
      hist[idx][0] = data;
      if (idx == NC - 1 && frames_seen < 4) frames_seen++;
    end
  endtask

  function automatic int randData();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // mode 0: c[k]=k, 1: ramp 10*f, 2: random, 3: extreme pattern by frame f.
  task automatic sendFrame(input int mode, input int f, input bit gaps);
    int val;
    for (int k = 0; k < NC; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0, randData(), 1'b0, 1'b0);
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 13, randData(), 1'b0, 1'b0);
        if ($urandom_range(0, 5) == 0)
          applyStimulus(1'b1, int'($urandom_range(14, 63)), randData(), 1'b0, 1'b0);
      end
      case (mode)
        0:       val = k;
        1:       val = 10 * f;
        3:       val = (f <= 1) ? -32768 : ((f == 2) ? 0 : 32767);
        default: val = randData();
      endcase
      applyStimulus(1'b1, k, val, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cycle        = 0;
    frames_seen  = 0;
    rst          = 1'b1;
    clear        = 1'b0;
    cep_in_valid = 1'b0;
    cep_in_idx   = '0;
    cep_in_data  = '0;
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < 4; j++) hist[k][j] = 0;

    $display("[TB] start");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 0, 123, 1'b0, 1'b1);
    idle(2);

    // Fill: four silent frames of c[k]=k, then a fifth that emits zeros.
    for (int f = 0; f < 5; f++) sendFrame(0, f, 1'b0);
    idle(3);

    // Linear ramp after clear: RUN deltas are 100.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    for (int f = 1; f <= 7; f++) sendFrame(1, f, 1'b0);
    idle(3);

    // Extremes: h4=h3=-32768, h1=c_t=+32767 gives 196605.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) sendFrame(3, f, 1'b0);
    idle(3);

    // Random data with valid gaps and out-of-range indices.
    for (int f = 0; f < 6; f++) sendFrame(2, f, 1'b1);
    idle(2);

    // Clear mid-frame in RUN with a coincident valid input.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, k, randData(), 1'b0, 1'b0);
    applyStimulus(1'b1, 6, randData(), 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) sendFrame(2, f, 1'b0);
    idle(1);

    // Reset in RUN with valid high drops in-flight results; refill afterwards.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, k, randData(), 1'b0, 1'b0);
    applyStimulus(1'b1, 5, randData(), 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) sendFrame(2, f, 1'b1);
    idle(4);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("[TB] FAIL drain observed %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
